// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the core run controller: FSM state encoding and run modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_HOLD  = 3'd1,
    RUN       = 3'd2,
    STEP_WAIT = 3'd3,
    STEP_EXEC = 3'd4,
    HALTED    = 3'd5,
    DUMP      = 3'd6,
    DONE      = 3'd7
  } state_e;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_LIMIT = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;

endpackage

// File: rtl/vram_dump_seq.sv
// VRAM scan sequencer: latches base/length, walks a word index, wraps the address.
// Latency: addr/valid/last are decoded from registers; index advances one cycle after accept.
// Backpressure: address holds while active && !ready; index steps only on valid && ready.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   start_dump     latch base/len and clear the index (accepted run start)
//   base, len      scan window, sampled on start_dump
//   active         controller is in its dump phase
//   ready          consumer accepts the current word
//   addr, valid    current VRAM address and its qualifier
//   last           current word is the final one of the window
//   empty          latched length is zero (no scan needed)
module vram_dump_seq #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              active,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              last,
  output logic              empty
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else if (start_dump) begin
      base_q <= base;
      len_q  <= len;
      idx_q  <= '0;
    end else if (active && ready) begin
      idx_q <= idx_q + LEN_W'(1);
    end
  end

  // Truncating add gives the wrap at the top of VRAM for free.
  assign addr  = base_q + idx_q[ADDR_W-1:0];
  assign valid = active;
  assign last  = (idx_q + LEN_W'(1)) == len_q;
  assign empty = (len_q == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: releases core reset, runs FREE/LIMIT/STEP, halts, then scans VRAM.
// Latency: all control outputs registered from next state; a start is visible one cycle later.
// Backpressure: dump words hold until dump_ready; start is ignored while busy.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, abort, step       run start pulse, early-stop level, single-step pulse
//   mode, cycle_limit        run mode and LIMIT budget, sampled on accepted start
//   cpu_stop_req             core ebreak/ecall stop indication
//   dump_base, dump_len      VRAM scan window, sampled on accepted start
//   dump_ready               consumer accepts the current dump word
//   cpu_rst, halt            core reset and clock-enable gate (halt=1 freezes)
//   vram_load, vram_addr     VRAM read-port select and address
//   dump_valid               vram_addr is presented to the consumer
//   busy, done               run in progress / run finished (level)
//   cycle_count              core cycles executed this run (saturating)
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 3,
  parameter int LEN_W      = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  cycle_limit,
  input  logic              step,
  input  logic              cpu_stop_req,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [LEN_W-1:0]  dump_len,
  input  logic              dump_ready,
  output logic              cpu_rst,
  output logic              halt,
  output logic              vram_load,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              dump_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  limit_q;
  logic              accept;
  logic              cpu_rst_q, halt_q, load_q, busy_q, done_q;
  logic              dump_last, dump_empty;

  // Saturating increment so a long free run never wraps back to small counts.
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RST_HOLD;
          hold_d  = '0;
          cyc_d   = '0;
        end
      end
      RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          if (mode_q == MODE_LIMIT && limit_q == '0) state_d = HALTED;
          else if (mode_q == MODE_STEP)               state_d = STEP_WAIT;
          else                                        state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        // The cycle that sees the stop request still executes, so it counts.
        cyc_d = cyc_inc;
        if (abort || cpu_stop_req || (mode_q == MODE_LIMIT && cyc_inc == limit_q))
          state_d = HALTED;
      end
      STEP_WAIT: begin
        if (abort || cpu_stop_req) state_d = HALTED;
        else if (step)             state_d = STEP_EXEC;
      end
      STEP_EXEC: begin
        cyc_d   = cyc_inc;
        state_d = cpu_stop_req ? HALTED : STEP_WAIT;
      end
      HALTED: state_d = dump_empty ? DONE : DUMP;
      DUMP: begin
        if (abort)                                   state_d = DONE;
        else if (dump_valid && dump_ready && dump_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      cyc_q     <= '0;
      mode_q    <= MODE_FREE;
      limit_q   <= '0;
      cpu_rst_q <= 1'b1;
      halt_q    <= 1'b1;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      if (accept) begin
        // Reserved encoding 2'b11 runs as FREE.
        mode_q  <= (mode == MODE_LIMIT || mode == MODE_STEP) ? mode : MODE_FREE;
        limit_q <= cycle_limit;
      end
      // Outputs registered from the next state so they line up with state_q.
      cpu_rst_q <= (state_d == IDLE) || (state_d == RST_HOLD);
      halt_q    <= !((state_d == RUN) || (state_d == STEP_EXEC));
      load_q    <= (state_d == DUMP);
      busy_q    <= !((state_d == IDLE) || (state_d == DONE));
      done_q    <= (state_d == DONE);
    end
  end

  vram_dump_seq #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .start_dump(accept),
    .base      (dump_base),
    .len       (dump_len),
    .active    (load_q),
    .ready     (dump_ready),
    .addr      (vram_addr),
    .valid     (dump_valid),
    .last      (dump_last),
    .empty     (dump_empty)
  );

  assign cpu_rst     = cpu_rst_q;
  assign halt        = halt_q;
  assign vram_load   = load_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, step, cpu_stop_req, dump_ready;
  logic [1:0]  mode;
  logic [31:0] cycle_limit;
  logic [12:0] dump_base;
  logic [13:0] dump_len;
  logic        cpu_rst, halt, vram_load, dump_valid, busy, done;
  logic [12:0] vram_addr;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint cyc;
    int     rst_cyc;
    int     halt_low;
    int     windows;
    int     acc;
  } done_exp_t;

  done_exp_t   exp_done[$];
  logic [12:0] exp_addr[$];

  cpu_run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .cycle_limit (cycle_limit),
    .step        (step),
    .cpu_stop_req(cpu_stop_req),
    .dump_base   (dump_base),
    .dump_len    (dump_len),
    .dump_ready  (dump_ready),
    .cpu_rst     (cpu_rst),
    .halt        (halt),
    .vram_load   (vram_load),
    .vram_addr   (vram_addr),
    .dump_valid  (dump_valid),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_halt"}, halt, 1);
    chk({tag, "_vram_load"}, vram_load, 0);
    chk({tag, "_vram_addr"}, vram_addr, 0);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // which: 0 halt low, 1 dump_valid, 2 done, 3 cpu_rst low
  task automatic wait_sig(input int which, input string name);
    bit hit;
    for (int i = 0; i < 500; i++) begin
      case (which)
        0:       hit = !halt;
        1:       hit = dump_valid;
        2:       hit = done;
        default: hit = !cpu_rst;
      endcase
      if (hit) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_%s: timed out after 500 cycles", name);
  endtask

  task automatic push_done(input longint c, input int r, input int hl, input int w, input int a);
    done_exp_t e;
    e.cyc = c; e.rst_cyc = r; e.halt_low = hl; e.windows = w; e.acc = a;
    exp_done.push_back(e);
  endtask

  task automatic run_start(input logic [1:0] m, input logic [31:0] lim,
                           input logic [12:0] base, input logic [13:0] len);
    mode = m; cycle_limit = lim; dump_base = base; dump_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_cnt_clear", cycle_count, 0);
    chk("start_cpu_rst", cpu_rst, 1);
  endtask

  // Monitor: measures each run and scores dump words and run completions.
  int  m_rst, m_hl, m_win, m_acc;
  bit  prev_busy = 1'b0, prev_done = 1'b0, prev_halt = 1'b1;
  logic [12:0] ea;
  done_exp_t   ed;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      m_rst = 0; m_hl = 0; m_win = 0; m_acc = 0;
    end
    if (busy && cpu_rst) m_rst++;
    if (!halt) begin
      m_hl++;
      if (prev_halt) m_win++;
    end
    if (dump_valid && dump_ready) begin
      if (exp_addr.size() == 0) chk("dump_unexpected", 1, 0);
      else begin
        ea = exp_addr.pop_front();
        chk("dump_addr", vram_addr, ea);
        m_acc++;
      end
    end else if (dump_valid && exp_addr.size() != 0) begin
      chk("dump_hold", vram_addr, exp_addr[0]);
    end
    if (done && !prev_done) begin
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        ed = exp_done.pop_front();
        chk("cycle_count", cycle_count, ed.cyc);
        chk("rst_cycles", m_rst, ed.rst_cyc);
        chk("halt_low_cycles", m_hl, ed.halt_low);
        chk("halt_low_windows", m_win, ed.windows);
        chk("dump_accepted", m_acc, ed.acc);
      end
    end
    prev_busy = busy;
    prev_done = done;
    prev_halt = halt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [5];
    rst = 1'b1; start = 0; abort = 0; step = 0; cpu_stop_req = 0; dump_ready = 0;
    mode = 0; cycle_limit = 0; dump_base = 0; dump_len = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    tick();

    // abort in IDLE has no effect
    abort = 1; tick(); abort = 0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_cpu_rst", cpu_rst, 1);

    // LIMIT 10, no dump
    push_done(10, 3, 10, 1, 0);
    run_start(2'd1, 10, 0, 0);
    wait_sig(2, "done_limit10");
    @(negedge clk); #1;
    abort = 1; tick(); abort = 0;
    chk("abort_done_level", done, 1);
    tick();

    // LIMIT with zero budget: straight to HALTED, core never runs
    push_done(0, 3, 0, 0, 0);
    run_start(2'd1, 0, 0, 0);
    wait_sig(2, "done_limit0");
    tick();

    // FREE, stop request on RUN cycle 25
    push_done(25, 3, 25, 1, 0);
    run_start(2'd0, 0, 0, 0);
    wait_sig(0, "run_free");
    repeat (24) tick();
    cpu_stop_req = 1; tick(); cpu_stop_req = 0;
    tick();
    chk("halt_after_stop", halt, 1);
    wait_sig(2, "done_free");
    tick();

    // STEP: 4 pulses spaced 3 cycles, extra pulse during STEP_EXEC
    push_done(4, 3, 4, 4, 0);
    run_start(2'd2, 0, 0, 0);
    wait_sig(3, "step_wait");
    for (int i = 0; i < 4; i++) begin
      step = 1; tick();
      step = (i == 1); tick();
      step = 0; tick();
    end
    abort = 1; tick(); abort = 0;
    wait_sig(2, "done_step");
    tick();

    // Dump across the top of VRAM with a stalled consumer
    exp_addr.push_back(13'd8190); exp_addr.push_back(13'd8191);
    exp_addr.push_back(13'd0);    exp_addr.push_back(13'd1);
    push_done(5, 3, 5, 1, 4);
    run_start(2'd1, 5, 13'd8190, 14'd4);
    wait_sig(1, "dump_wrap");
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      dump_ready = pat[i];
      tick();
    end
    dump_ready = 0;
    wait_sig(2, "done_dump");
    tick();

    // LIMIT 100 aborted at RUN cycle 40, then abort mid-dump
    exp_addr.push_back(13'd100); exp_addr.push_back(13'd101);
    push_done(40, 3, 40, 1, 2);
    run_start(2'd1, 100, 13'd100, 14'd5);
    wait_sig(0, "run_abort");
    repeat (39) tick();
    abort = 1; tick(); abort = 0;
    wait_sig(1, "dump_abort");
    dump_ready = 1; tick(); tick();
    dump_ready = 0; abort = 1; tick(); abort = 0;
    chk("abort_dump_done", done, 1);
    tick();

    // Reset during DUMP (mode 3 runs as FREE)
    run_start(2'd3, 0, 13'd5, 14'd3);
    wait_sig(0, "run_mode3");
    repeat (3) tick();
    cpu_stop_req = 1; tick(); cpu_stop_req = 0;
    wait_sig(1, "dump_rst");
    #3 rst = 1'b1;
    #1 check_reset("rst_in_dump");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Fresh run; a start while busy must be ignored
    push_done(8, 3, 8, 1, 0);
    run_start(2'd1, 8, 0, 0);
    wait_sig(0, "run_fresh");
    tick(); tick();
    cycle_limit = 2; mode = 2'd2; start = 1; tick(); start = 0;
    chk("start_while_busy", busy, 1);
    wait_sig(2, "done_fresh");
    repeat (3) tick();

    chk("done_queue_empty", exp_done.size(), 0);
    chk("addr_queue_empty", exp_addr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run controller for the single-cycle RISC-V core and its VRAM.
- Sequences core reset release, runs the core in one of three modes, then halts it and scans a window of VRAM.
- Mode 0 is free-run. Mode 1 is a cycle budget. Mode 2 is single-step.
- Drives the core's rst, halt, vram_load and vram_addr pins; replaces fixed-delay bench sequencing for board bring-up and regression.

Parameters:
- ADDR_W, 13, VRAM word-address width.
- CNT_W, 32, cycle counter and budget width.
- RST_CYCLES, 3, cycles cpu_rst is held after start (minimum 1).
- LEN_W, ADDR_W+1, dump length width (allows a full-VRAM dump).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
- abort  in  1  level; forces an early stop.
- mode  in  2  00 FREE, 01 LIMIT, 10 STEP, 11 treated as FREE; sampled on accepted start.
- cycle_limit  in  CNT_W  budget for LIMIT mode; sampled on start.
- step  in  1  one-cycle pulse; releases one core cycle in STEP mode.
- cpu_stop_req  in  1  core's ebreak/ecall stop indication.
- dump_base  in  ADDR_W  first VRAM address to scan; sampled on start.
- dump_len  in  LEN_W  number of words to scan; sampled on start.
- dump_ready  in  1  consumer accepts the current dump word.
- cpu_rst  out  1  core reset.
- halt  out  1  core clock-enable gate (1 = frozen).
- vram_load  out  1  VRAM read-port select.
- vram_addr  out  ADDR_W  VRAM read address.
- dump_valid  out  1  vram_addr is valid for the consumer.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high (level) in DONE.
- cycle_count  out  CNT_W  core cycles executed this run.

Behaviour:
- Reset values: state IDLE, cpu_rst=1, halt=1, vram_load=0, vram_addr=0, dump_valid=0, busy=0, done=0, cycle_count=0. Reset mid-run returns to IDLE immediately; no dump completes.
- All outputs are registered or decoded from the registered state only.
- IDLE: cpu_rst=1, halt=1.
  - start -> RST_HOLD.
  - On accepted start: latch mode, cycle_limit, dump_base and dump_len; clear cycle_count and the hold counter.
- RST_HOLD: cpu_rst=1, halt=1 for exactly RST_CYCLES cycles. Then:
  - LIMIT with cycle_limit==0 -> HALTED.
  - STEP -> STEP_WAIT.
  - otherwise -> RUN.
- RUN: cpu_rst=0, halt=0; cycle_count increments every cycle and saturates at all-ones.
  - Exit to HALTED on abort or cpu_stop_req; the cycle in which the request is seen still counts.
  - In LIMIT, exit after exactly cycle_limit RUN cycles (cycle_count==cycle_limit on entry to HALTED).
- STEP_WAIT: cpu_rst=0, halt=1.
  - step -> STEP_EXEC.
  - abort or cpu_stop_req -> HALTED, with priority over step.
- STEP_EXEC: halt=0 for exactly one cycle; cycle_count+1; -> STEP_WAIT, or HALTED if cpu_stop_req.
  - A step pulse arriving in STEP_EXEC is ignored.
- HALTED: halt=1, cpu_rst=0, one cycle. -> DUMP if dump_len!=0, else -> DONE.
- DUMP: vram_load=1, dump_valid=1, vram_addr=dump_base+idx, modulo 2^ADDR_W (wraps at the top of VRAM).
  - idx advances only on dump_valid&&dump_ready.
  - After dump_len accepted words -> DONE.
  - abort in DUMP -> DONE immediately; words already accepted stand.
- DONE: done=1, halt=1, cpu_rst=0, vram_load=0. Core state stays visible.
  - start -> RST_HOLD, latching new inputs.
- start while busy is ignored.
- abort in IDLE or DONE has no effect.
- Simultaneous cpu_stop_req and LIMIT expiry resolve as one transition to HALTED.

Decomposition:
- Package cpu_run_ctrl_pkg holds:
  - the state enum (IDLE, RST_HOLD, RUN, STEP_WAIT, STEP_EXEC, HALTED, DUMP, DONE);
  - the MODE_FREE, MODE_LIMIT and MODE_STEP constants.
- Sub-module vram_dump_seq holds the base/length latch, the idx counter, the wrap-around address adder and last-word detection. It takes start_dump and ready, and returns addr, valid and last.
- The top level keeps the FSM, hold counter and cycle counter.

Test Plan:
- LIMIT, cycle_limit=10, dump_len=0, RST_CYCLES=3 -> cpu_rst high 3 cycles after start; halt low exactly 10 cycles; done with cycle_count=10.
- FREE, cpu_stop_req asserted on RUN cycle 25 -> HALTED next cycle; cycle_count=25; halt=1 thereafter.
- STEP, 4 step pulses spaced 3 cycles, one extra pulse during STEP_EXEC -> exactly 4 single-cycle halt-low windows; cycle_count=4.
- Dump with dump_base=8190, dump_len=4, dump_ready toggling 1,0,1,1,1 -> addresses 8190, 8191, 0, 1 each held until accepted; then done.
- abort asserted mid-RUN in LIMIT with cycle_limit=100 at cycle 40 -> cycle_count=40; dump runs; a second abort in DUMP goes straight to DONE.
- rst pulse during DUMP -> all outputs at reset values asynchronously; after release, start begins a fresh run with cycle_count=0.
